// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Optional byte/half stores are enabled with DMEM_BYTEWRITE_EN.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int CNT_W = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage data-memory bus between the datapath and dmem_responder.
// sizeM exists only when DMEM_BYTEWRITE_EN is defined.
interface dmem_responder_if;
   logic [31:0] addrM;
   logic [31:0] writedataM;
   logic        memwriteM;
   logic        memreadM;
`ifdef DMEM_BYTEWRITE_EN
   logic [1:0]  sizeM;
`endif
   logic [31:0] readdataM;
   logic        memstallM;
   logic        memerrM;

`ifdef DMEM_BYTEWRITE_EN
   modport master (output addrM, writedataM, memwriteM, memreadM, sizeM,
                   input  readdataM, memstallM, memerrM);
   modport slave  (input  addrM, writedataM, memwriteM, memreadM, sizeM,
                   output readdataM, memstallM, memerrM);
`else
   modport master (output addrM, writedataM, memwriteM, memreadM,
                   input  readdataM, memstallM, memerrM);
   modport slave  (input  addrM, writedataM, memwriteM, memreadM,
                   output readdataM, memstallM, memerrM);
`endif
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables.
// Synchronous write, combinational read; contents are never reset.
module dmem_array #(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [3:0]           be,
   input  logic [ADDR_BITS-1:0] index,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem_q [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[index][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem_q[index];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline LATENCY cycles per access.
// Define DMEM_BYTEWRITE_EN to add sizeM and byte/half store merging.
//
// state | meaning
// IDLE  | no access outstanding; a request raises memstallM this cycle
// WAIT  | access outstanding; cnt counts down to the access edge
// DONE  | one-cycle result window for readdataM / memerrM
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   dmem_responder_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;

   logic                 req;
   logic                 access;
   logic                 stall;
   logic                 misaligned;
   logic                 we;
   logic [3:0]           be;
   logic [31:0]          wdata;
   logic [31:0]          arr_rdata;
   logic [ADDR_BITS-1:0] index;
   logic                 unused_addr_bits;

   assign req              = bus.memreadM | bus.memwriteM;
   assign index            = bus.addrM[ADDR_BITS+1:2];
   assign unused_addr_bits = ^bus.addrM[31:ADDR_BITS+2];

`ifdef DMEM_BYTEWRITE_EN
   // Store data arrives right-justified; replicate it so every lane sees it.
   always_comb begin
      misaligned = 1'b0;
      be         = 4'b1111;
      wdata      = bus.writedataM;
      case (bus.sizeM)
         SZ_BYTE: begin
            be    = 4'b0001 << bus.addrM[1:0];
            wdata = {4{bus.writedataM[7:0]}};
         end
         SZ_HALF: begin
            misaligned = bus.addrM[0];
            be         = bus.addrM[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{bus.writedataM[15:0]}};
         end
         SZ_WORD: misaligned = |bus.addrM[1:0];
         default: misaligned = 1'b1;
      endcase
   end
`else
   assign misaligned = |bus.addrM[1:0];
   assign be         = 4'b1111;
   assign wdata      = bus.writedataM;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      access  = 1'b0;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               stall = 1'b1;
               if (LATENCY == 1) begin
                  access  = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d   = CNT_START;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            stall = 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_LAST) begin
               access  = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Array read is combinational, so this captures the pre-write word.
      if (access) begin
         rdata_d = misaligned ? 32'h0 : arr_rdata;
         err_d   = misaligned;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Reset also blocks the LATENCY=1 same-cycle write path.
   assign we = access & ~rst & bus.memwriteM & ~misaligned;

   dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
      .clk   (clk),
      .we    (we),
      .be    (be),
      .index (index),
      .wdata (wdata),
      .rdata (arr_rdata)
   );

   assign bus.memstallM = stall & ~rst;
   assign bus.readdataM = (state_q == DONE) ? rdata_q : 32'h0;
   assign bus.memerrM   = (state_q == DONE) ? err_q   : 1'b0;

endmodule
